jpeg_block_sequencer: RTL and testbench
=======================================

// Module: jpeg_block_sequencer
// PURPOSE
//  Job-level sequencer for the JPEG 8x8 block pipeline (input RAM -> DCT -> quant -> zig-zag).
//  On a start pulse it clears the datapath and streams read addresses for num_blocks
//  consecutive 64-sample blocks to the input and quant-table memories.
//  It asserts the zig-zag enable once the pipeline is full, then reports done.
//  It supports downstream backpressure (stall) and a continuous multi-block stream.
// PARAMETERS
//  ADDR_W        6    sample address width; block = 2**ADDR_W = 64 samples
//  BLK_W         12   width of block count/index
//  PIPE_LAT      106  ce cycles from first input address to first valid zig-zag sample
//  QUANT_OFFSET  47   quant address = (addr_input + QUANT_OFFSET) mod 64
// PORTS
//  clk          in   1       clock, rising edge
//  rst_n        in   1       asynchronous active-low reset
//  start        in   1       job start pulse; sampled only in IDLE
//  num_blocks   in   BLK_W   block count; latched on accepted start
//  stall        in   1       downstream backpressure; freezes RUN
//  dp_clr       out  1       one-cycle synchronous clear for the datapath
//  ce           out  1       datapath clock enable
//  addr_input   out  ADDR_W  input sample RAM address
//  addr_quant   out  ADDR_W  quant table ROM address
//  ce_zig_zag   out  1       zig-zag stage enable (valid output sample)
//  blk_idx      out  BLK_W   block index of the current addr_input
//  busy         out  1       high in CLEAR, RUN and DONE
//  done         out  1       one-cycle job-complete pulse
// BEHAVIOUR
//  - Reset values: dp_clr=0, ce=0, addr_input=0, addr_quant=QUANT_OFFSET, ce_zig_zag=0,
//    blk_idx=0, busy=0, done=0, state=IDLE. Reset acts immediately, including mid-job.
//  - All outputs are registered.
//  - FSM:
//    IDLE -> CLEAR when start=1 and num_blocks!=0.
//    IDLE -> DONE when start=1 and num_blocks==0.
//    CLEAR -> RUN after 1 cycle.
//    RUN -> DONE after the last zig-zag sample.
//    DONE -> IDLE after 1 cycle.
//  - Start accepted at edge k: dp_clr=1 during k+1, so addr_input=0 and addr_quant=QUANT_OFFSET there.
//  - First ce=1 cycle (c=0) is k+2, with addr_input=0.
//  - RUN, stall=0: ce=1. After each ce cycle, addr_input and addr_quant each advance by 1 (wrapping mod 64).
//  - Input side: on each 63->0 wrap of addr_input, blk_idx increments.
//    After N*64 ce cycles blk_idx holds N-1; addresses keep wrapping (downstream discards those reads).
//  - Output side: ce_zig_zag=1 exactly for ce cycles c in [PIPE_LAT, PIPE_LAT+N*64-1]. It is contiguous across block boundaries.
//  - RUN, stall=1: ce=0 and ce_zig_zag=0. All counters and addresses hold, and the cycle is not counted.
//    Stall in IDLE, CLEAR or DONE has no effect.
//  - done=1 in the cycle after the last ce_zig_zag cycle (DONE state). busy falls the cycle after that.
//  - start while busy=1 is ignored; num_blocks is not re-sampled.
//  - Internal counters: ce-cycle counter of width >= clog2(PIPE_LAT) + BLK_W + ADDR_W.
//    The output sample counter compares against {num_blocks_q, 6'd0} - 1. There is no overflow at
//    num_blocks = 2**BLK_W - 1.
// STRUCTURE
//  - Package jpeg_ctrl_pkg holds BLK_SAMPLES=64, ADDR_W, the PIPE_LAT and QUANT_OFFSET defaults,
//    and the FSM state encoding (IDLE, CLEAR, RUN, DONE).
//  - Sub-module jpeg_sample_counter is a 6-bit address counter with enable, sync clear,
//    load value, and wrap carry out. It is instantiated twice: input address/blk_idx, and output sample count.
//  - Quant address is a separate register loaded with QUANT_OFFSET on clear and advanced on ce.
// TESTING
//  1. rst_n=0, then release -> all outputs at reset values, addr_quant=47, and they stay so with start=0.
//  2. num_blocks=1 and a start pulse:
//     -> dp_clr for 1 cycle; addr_input 0..63; addr_quant 47..63 then 0..46;
//     -> ce_zig_zag high for ce cycles 106..169; done at cycle 170 relative to first ce; busy then drops.
//  3. num_blocks=3:
//     -> addr_input wraps 63->0 twice; blk_idx steps 0,1,2;
//     -> ce_zig_zag is one unbroken 192-cycle window starting at c=106; a single done pulse.
//  4. num_blocks=2 with stall=1 for 5 cycles when addr_input=20, and again for 3 cycles inside the zig-zag window:
//     -> ce=0 and everything holds; resumes at 20; done is delayed by exactly 8 cycles.
//  5. start pulsed again mid-job -> ignored, no effect on counters.
//     num_blocks=0 -> done the cycle after start, ce never asserted.
//  6. rst_n low at ce cycle 50 of a 2-block job -> outputs at reset values immediately.
//     A new 1-block job afterwards completes with the same timing as test 2.

Source files
------------

// File: rtl/jpeg_ctrl_pkg.sv
// Shared constants and FSM encoding for the JPEG block sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package jpeg_ctrl_pkg;

  localparam int ADDR_W           = 6;
  localparam int BLK_SAMPLES      = 1 << ADDR_W;
  localparam int BLK_W_DEF        = 12;
  localparam int PIPE_LAT_DEF     = 106;
  localparam int QUANT_OFFSET_DEF = 47;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/jpeg_sample_counter.sv
// Sample-address counter inside an 8x8 block, with wrap carry to count whole blocks.
// Latency: count updates on the edge after en; wrap is combinational from en and count.
// Backpressure: holds its value whenever en is low.
module jpeg_sample_counter
  import jpeg_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] cnt,
  output logic              wrap
);

  // Carry out on the 63 -> 0 step; a clear takes priority, so it never wraps then.
  assign wrap = en && !clr && (cnt == {ADDR_W{1'b1}});

  // Clear loads the start value; otherwise count on enable, wrapping naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= cnt + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/jpeg_block_sequencer.sv
// Job sequencer: clears the datapath, streams input/quant addresses for N blocks, gates zig-zag output.
// Latency: dp_clr 1 cycle after start, first ce 2 cycles after start, zig-zag after PIPE_LAT ce cycles.
// Backpressure: stall sampled in RUN drops ce (and ce_zig_zag) next cycle; all counters hold.
module jpeg_block_sequencer
  import jpeg_ctrl_pkg::*;
#(
  parameter int BLK_W        = BLK_W_DEF,
  parameter int PIPE_LAT     = PIPE_LAT_DEF,
  parameter int QUANT_OFFSET = QUANT_OFFSET_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [BLK_W-1:0]  num_blocks,
  input  logic              stall,
  output logic              dp_clr,
  output logic              ce,
  output logic [ADDR_W-1:0] addr_input,
  output logic [ADDR_W-1:0] addr_quant,
  output logic              ce_zig_zag,
  output logic [BLK_W-1:0]  blk_idx,
  output logic              busy,
  output logic              done
);

  // ce-cycle counter is wide enough for the full job plus pipeline fill.
  localparam int CNT_W = $clog2(PIPE_LAT) + BLK_W + ADDR_W;
  localparam int OUT_W = BLK_W + ADDR_W;
  localparam logic [ADDR_W-1:0] QOFF = ADDR_W'(QUANT_OFFSET % BLK_SAMPLES);
  localparam logic [CNT_W-1:0]  LAT  = CNT_W'(PIPE_LAT);

  state_t            state_q;
  state_t            state_d;
  logic [BLK_W-1:0]  nblk_q;
  logic [CNT_W-1:0]  ce_cnt_q;
  logic [CNT_W-1:0]  ce_cnt_nxt;
  logic [BLK_W-1:0]  out_blk_q;
  logic [ADDR_W-1:0] out_smp;
  logic [OUT_W-1:0]  out_cnt;
  logic [OUT_W-1:0]  out_last;
  logic              in_wrap;
  logic              out_wrap;
  logic              clr;
  logic              last_smp;
  logic              ce_d;
  logic              zz_d;

  // Any start seen in IDLE re-initialises every counter, including zero-block jobs.
  assign clr        = (state_q == IDLE) && start;
  assign out_cnt    = {out_blk_q, out_smp};
  assign out_last   = {nblk_q, {ADDR_W{1'b0}}} - OUT_W'(1);
  assign last_smp   = ce_zig_zag && (out_cnt == out_last);
  // Index of the ce cycle that the next cycle would be, if it is a ce cycle.
  assign ce_cnt_nxt = ce_cnt_q + CNT_W'(ce);

  // Input side: sample address within the block; wraps feed the block index.
  jpeg_sample_counter u_in_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (ce),
    .clr      (clr),
    .load_val ({ADDR_W{1'b0}}),
    .cnt      (addr_input),
    .wrap     (in_wrap)
  );

  // Output side: zig-zag samples emitted so far (low bits), block count above.
  jpeg_sample_counter u_out_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (ce_zig_zag),
    .clr      (clr),
    .load_val ({ADDR_W{1'b0}}),
    .cnt      (out_smp),
    .wrap     (out_wrap)
  );

  // Next state plus the look-ahead values that the output registers capture.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (num_blocks != '0) ? CLEAR : DONE;
      CLEAR:   state_d = RUN;
      RUN:     if (last_smp) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Stall only matters once RUN is active; CLEAR always hands over to a ce cycle.
    ce_d = (state_d == RUN) && !(stall && (state_q == RUN));
    zz_d = ce_d && (ce_cnt_nxt >= LAT);
  end

  // State and registered control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dp_clr     <= 1'b0;
      ce         <= 1'b0;
      ce_zig_zag <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      nblk_q     <= '0;
    end else begin
      state_q    <= state_d;
      dp_clr     <= (state_d == CLEAR);
      ce         <= ce_d;
      ce_zig_zag <= zz_d;
      busy       <= (state_d != IDLE);
      done       <= (state_d == DONE);
      if (clr) nblk_q <= num_blocks;
    end
  end

  // Job counters: ce cycles, quant address, input block index, output block count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_cnt_q   <= '0;
      addr_quant <= QOFF;
      blk_idx    <= '0;
      out_blk_q  <= '0;
    end else if (clr) begin
      ce_cnt_q   <= '0;
      addr_quant <= QOFF;
      blk_idx    <= '0;
      out_blk_q  <= '0;
    end else begin
      if (ce) begin
        ce_cnt_q   <= ce_cnt_nxt;
        addr_quant <= addr_quant + ADDR_W'(1);
      end
      // Block index parks on the last block while the pipeline drains.
      if (in_wrap && (blk_idx != nblk_q - BLK_W'(1))) blk_idx <= blk_idx + BLK_W'(1);
      if (out_wrap) out_blk_q <= out_blk_q + BLK_W'(1);
    end
  end

endmodule

// File: tb/tb_jpeg_block_sequencer.sv
// Directed bench for jpeg_block_sequencer with a per-ce-cycle address scoreboard.
// Latency: checks dp_clr, first ce, zig-zag window and done timing against a cycle model.
// Backpressure: injects stalls in RUN, CLEAR, IDLE and DONE and checks hold behaviour.
module tb_jpeg_block_sequencer;

  localparam int LAT  = 106;
  localparam int QOFF = 47;
  localparam logic [28:0] RST_SNAP  = {1'b0, 1'b0, 6'd0, 6'd47, 1'b0, 12'd0, 1'b0, 1'b0};
  localparam logic [28:0] CLR_SNAP  = {1'b1, 1'b0, 6'd0, 6'd47, 1'b0, 12'd0, 1'b1, 1'b0};
  localparam logic [28:0] ZERO_SNAP = {1'b0, 1'b0, 6'd0, 6'd47, 1'b0, 12'd0, 1'b1, 1'b1};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [11:0] num_blocks;
  logic        stall;
  logic        dp_clr;
  logic        ce;
  logic [5:0]  addr_input;
  logic [5:0]  addr_quant;
  logic        ce_zig_zag;
  logic [11:0] blk_idx;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_err = 0;
  logic [24:0] exp_q[$];

  jpeg_block_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_blocks (num_blocks),
    .stall      (stall),
    .dp_clr     (dp_clr),
    .ce         (ce),
    .addr_input (addr_input),
    .addr_quant (addr_quant),
    .ce_zig_zag (ce_zig_zag),
    .blk_idx    (blk_idx),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [28:0] snap();
    return {dp_clr, ce, addr_input, addr_quant, ce_zig_zag, blk_idx, busy, done};
  endfunction

  // Expected {addr_input, addr_quant, ce_zig_zag, blk_idx} for ce cycle c of an n-block job.
  function automatic logic [24:0] exp_vec(input int c, input int n);
    int b;
    b = c / 64;
    if (b > n - 1) b = n - 1;
    return {6'(c % 64), 6'((c + QOFF) % 64), (c >= LAT), 12'(b)};
  endfunction

  // Scoreboard: every ce cycle consumes one expected entry; zig-zag never without ce.
  always @(negedge clk) begin
    if (ce === 1'b1) begin
      if (exp_q.size() == 0) chk("ce_unexpected", 64'(ce), 64'd0);
      else chk("ce_cycle", {addr_input, addr_quant, ce_zig_zag, blk_idx}, exp_q.pop_front());
    end else begin
      chk("zz_without_ce", 64'(ce_zig_zag), 64'd0);
    end
  end

  task automatic run_job(input int n, input int s1, input int s2, input bit stall_clr,
                         input bit restart, input int rst_c);
    int cyc, ce_seen, zz_seen, rem, hold, exp_done;
    bit got_done, trig1, trig2, aborted, in_stall;
    cyc = 0; ce_seen = 0; zz_seen = 0; rem = 0; hold = 0;
    got_done = 0; trig1 = 0; trig2 = 0; aborted = 0; in_stall = 0;
    exp_done = 1 + LAT + 64 * n + s1 + s2;
    for (int c = 0; c < LAT + 64 * n; c++) exp_q.push_back(exp_vec(c, n));
    num_blocks = 12'(n);
    start = 1'b1;
    stall = stall_clr;
    @(negedge clk);
    start = 1'b0;
    chk("clear_cycle", snap(), CLR_SNAP);
    while (!got_done && !aborted && cyc < exp_done + 50) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) stall = 1'b0;
      if (restart && cyc == 40) begin start = 1'b1; num_blocks = 12'd7; end
      if (restart && cyc == 41) begin start = 1'b0; num_blocks = 12'(n); end
      if (rst_c >= 0 && ce === 1'b1 && ce_seen == rst_c) begin
        rst_n = 1'b0;
        #1;
        chk("reset_mid_job", snap(), RST_SNAP);
        aborted = 1;
      end else begin
        chk("busy_no_clr", {dp_clr, busy}, 2'b01);
        if (in_stall) begin
          chk("stall_hold", {ce, ce_zig_zag, addr_input}, {2'b00, 6'(hold)});
          rem--;
          if (rem == 0) begin stall = 1'b0; in_stall = 0; end
        end else if (s1 > 0 && !trig1 && ce === 1'b1 && addr_input == 6'd19 && blk_idx == 12'd0) begin
          stall = 1'b1; in_stall = 1; rem = s1; trig1 = 1; hold = 20;
        end else if (s2 > 0 && !trig2 && ce_zig_zag === 1'b1 && zz_seen == 30) begin
          stall = 1'b1; in_stall = 1; rem = s2; trig2 = 1; hold = (int'(addr_input) + 1) % 64;
        end
        if (done === 1'b1) got_done = 1;
        if (ce === 1'b1) ce_seen++;
        if (ce_zig_zag === 1'b1) zz_seen++;
      end
    end
    stall = 1'b0;
    if (aborted) begin
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      @(negedge clk);
      chk("post_reset_idle", snap(), RST_SNAP);
    end else begin
      chk("done_seen", 64'(got_done), 64'd1);
      chk("done_cycle", 64'(cyc), 64'(exp_done));
      chk("done_state", {ce, ce_zig_zag, busy}, 3'b001);
      chk("ce_count", 64'(ce_seen), 64'(LAT + 64 * n));
      chk("zz_count", 64'(zz_seen), 64'(64 * n));
      chk("sb_drained", 64'(exp_q.size()), 64'd0);
      @(negedge clk);
      chk("after_done", {ce, busy, done}, 3'b000);
      exp_q.delete();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    num_blocks = '0;
    repeat (2) @(negedge clk);
    chk("in_reset", snap(), RST_SNAP);
    rst_n = 1'b1;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_after_reset", snap(), RST_SNAP);
    end
    stall = 1'b0;

    run_job(1, 0, 0, 1'b0, 1'b0, -1);
    run_job(3, 0, 0, 1'b1, 1'b0, -1);
    run_job(2, 5, 3, 1'b0, 1'b0, -1);
    run_job(2, 0, 0, 1'b0, 1'b1, -1);

    num_blocks = 12'd0;
    start = 1'b1;
    stall = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("zero_blk_done", snap(), ZERO_SNAP);
    @(negedge clk);
    stall = 1'b0;
    chk("zero_blk_idle", snap(), RST_SNAP);

    run_job(2, 0, 0, 1'b0, 1'b0, 50);
    run_job(1, 0, 0, 1'b0, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
